// File: rtl/alu_operand_forward_unit.sv
// -----------------------------------------------------------------------------
// alu_operand_forward_unit
//
// ID/EX operand delivery. Each source operand is taken from the newest
// in-flight producer (ALU, then MEM, then WB) or from the register file read
// data, and registered into EX. A load in the ALU stage whose destination is
// read by the instruction in ID is a load-use hazard: IF/ID is stalled, EX
// gets a bubble, and the unit waits in LOAD_WAIT until the load data is
// valid in MEM. If memory stays not-ready too long, a sticky timeout is raised.
//
// Ports
//   clk, reset                   clock (rising edge), async active-low reset
//   id_valid                     ID holds a valid instruction
//   rs1_addr_id/rs2_addr_id      ID source register addresses
//   rs1_data_id/rs2_data_id      register file read data
//   rd_addr_alu/rd_we_alu        ALU-stage destination and write enable
//   is_load_alu, alu_result      ALU-stage load flag and result
//   rd_addr_mem/rd_we_mem        MEM-stage destination and write enable
//   mem_result, mem_ready        MEM-stage writeback value and load-data valid
//   rd_addr_wb/rd_we_wb, wb_data WB-stage destination, enable and data
//   operand1_ex/operand2_ex      registered EX operands
//   fwd_sel1_ex/fwd_sel2_ex      registered operand source: 0=RF 1=ALU 2=MEM 3=WB
//   ex_valid                     EX holds a valid instruction (0 = bubble)
//   stall_if_id                  combinational hold of PC and IF/ID
//   mem_timeout                  sticky: load data wait exceeded MAX_WAIT
// -----------------------------------------------------------------------------
module alu_operand_forward_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_WAIT       = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id,
    input  logic [DATA_WIDTH-1:0]     rs1_data_id,
    input  logic [DATA_WIDTH-1:0]     rs2_data_id,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_alu,
    input  logic                      rd_we_alu,
    input  logic                      is_load_alu,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_mem,
    input  logic                      rd_we_mem,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_wb,
    input  logic                      rd_we_wb,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic [DATA_WIDTH-1:0]     operand1_ex,
    output logic [DATA_WIDTH-1:0]     operand2_ex,
    output logic [1:0]                fwd_sel1_ex,
    output logic [1:0]                fwd_sel2_ex,
    output logic                      ex_valid,
    output logic                      stall_if_id,
    output logic                      mem_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_ALU = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    typedef enum logic {
        RUN       = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;

    // Register x0 is hard-wired zero and never forwarded.
    function automatic logic hit(input logic [REG_ADDR_WIDTH-1:0] src,
                                 input logic [REG_ADDR_WIDTH-1:0] rd,
                                 input logic                      we);
        return we && (rd != '0) && (rd == src);
    endfunction

    // Newest producer wins. A load in the ALU stage has no data yet, so it
    // cannot be a forwarding source (that case is the load-use stall).
    function automatic logic [1:0] pick_sel(input logic [REG_ADDR_WIDTH-1:0] src,
                                            input logic [REG_ADDR_WIDTH-1:0] rd_a,
                                            input logic                      we_a,
                                            input logic                      ld_a,
                                            input logic [REG_ADDR_WIDTH-1:0] rd_m,
                                            input logic                      we_m,
                                            input logic [REG_ADDR_WIDTH-1:0] rd_w,
                                            input logic                      we_w);
        if (!ld_a && hit(src, rd_a, we_a))
            return SEL_ALU;
        else if (hit(src, rd_m, we_m))
            return SEL_MEM;
        else if (hit(src, rd_w, we_w))
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pick_data(input logic [1:0]            sel,
                                                        input logic [DATA_WIDTH-1:0] rf,
                                                        input logic [DATA_WIDTH-1:0] a,
                                                        input logic [DATA_WIDTH-1:0] m,
                                                        input logic [DATA_WIDTH-1:0] w);
        case (sel)
            SEL_ALU: return a;
            SEL_MEM: return m;
            SEL_WB:  return w;
            default: return rf;
        endcase
    endfunction

    logic [1:0]            sel1_p0;
    logic [1:0]            sel2_p0;
    logic [DATA_WIDTH-1:0] op1_p0;
    logic [DATA_WIDTH-1:0] op2_p0;
    logic                  load_use;
    logic                  stall_c;

    // ---- ID stage: operand selection and hazard detection ----
    always_comb begin
        sel1_p0  = pick_sel(rs1_addr_id, rd_addr_alu, rd_we_alu, is_load_alu,
                            rd_addr_mem, rd_we_mem, rd_addr_wb, rd_we_wb);
        sel2_p0  = pick_sel(rs2_addr_id, rd_addr_alu, rd_we_alu, is_load_alu,
                            rd_addr_mem, rd_we_mem, rd_addr_wb, rd_we_wb);
        op1_p0   = pick_data(sel1_p0, rs1_data_id, alu_result, mem_result, wb_data);
        op2_p0   = pick_data(sel2_p0, rs2_data_id, alu_result, mem_result, wb_data);
        load_use = id_valid && is_load_alu &&
                   (hit(rs1_addr_id, rd_addr_alu, rd_we_alu) ||
                    hit(rs2_addr_id, rd_addr_alu, rd_we_alu));
    end

    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        case (state)
            RUN: begin
                stall_c = load_use;
                if (load_use)
                    state_next = LOAD_WAIT;
            end
            LOAD_WAIT: begin
                stall_c = !mem_ready;
                if (mem_ready)
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Reset is asynchronous, so the stall must drop with it, not at the next edge.
    assign stall_if_id = reset && stall_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // ---- EX stage register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operand1_ex <= '0;
            operand2_ex <= '0;
            fwd_sel1_ex <= SEL_RF;
            fwd_sel2_ex <= SEL_RF;
            ex_valid    <= 1'b0;
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (load_use) begin
                        operand1_ex <= '0;
                        operand2_ex <= '0;
                        fwd_sel1_ex <= SEL_RF;
                        fwd_sel2_ex <= SEL_RF;
                        ex_valid    <= 1'b0;
                        wait_cnt    <= '0;
                    end else begin
                        operand1_ex <= op1_p0;
                        operand2_ex <= op2_p0;
                        fwd_sel1_ex <= sel1_p0;
                        fwd_sel2_ex <= sel2_p0;
                        ex_valid    <= id_valid;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_ready) begin
                        // The load has reached MEM, so normal priority picks its data.
                        operand1_ex <= op1_p0;
                        operand2_ex <= op2_p0;
                        fwd_sel1_ex <= sel1_p0;
                        fwd_sel2_ex <= sel2_p0;
                        ex_valid    <= id_valid;
                    end else begin
                        ex_valid <= 1'b0;
                        if (wait_cnt == CNT_W'(MAX_WAIT))
                            mem_timeout <= 1'b1;
                        else
                            wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ex_valid <= 1'b0;
            endcase
        end
    end

endmodule
